// File: rtl/draw_layer_arbiter_pkg.sv
// draw_layer_arbiter_pkg: layer codes, fright states and default ghost colours
package draw_layer_arbiter_pkg;
  typedef enum logic [2:0] {
    LAYER_BG      = 3'd0,
    LAYER_DOTS    = 3'd1,
    LAYER_BORDERS = 3'd2,
    LAYER_GHOSTS  = 3'd3,
    LAYER_PACMAN  = 3'd4
  } layer_e;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FRIGHT = 2'd1,
    ST_FLASH  = 2'd2
  } fright_state_e;
  localparam logic [7:0] DEFAULT_FRIGHT_RGB = 8'h03;
  localparam logic [7:0] DEFAULT_FLASH_RGB  = 8'hFF;
endpackage

// File: rtl/draw_layer_arbiter_fright_timer.sv
// fright_timer: frightened/flash state machine counting frames since a power pellet
module fright_timer
  import draw_layer_arbiter_pkg::*;
#(
  parameter int FRIGHT_FRAMES = 360,
  parameter int FLASH_FRAMES  = 120,
  parameter int FLASH_PERIOD  = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_of_frame,
  input  logic          fright_start,
  output fright_state_e state,
  output logic          flash_phase,
  output logic          fright_active
);
  localparam int CW = FRIGHT_FRAMES > 1 ? $clog2(FRIGHT_FRAMES) : 1;
  localparam int FW = FLASH_PERIOD > 1 ? $clog2(FLASH_PERIOD) : 1;
  localparam logic [CW-1:0] FLASH_AT   = CW'(FRIGHT_FRAMES - FLASH_FRAMES - 1);
  localparam logic [CW-1:0] LAST_FRAME = CW'(FRIGHT_FRAMES - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_PERIOD - 1);
  fright_state_e state_q, state_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic          flash_phase_q, flash_phase_d;
  logic          fright_active_q, fright_active_d;
  // A pellet always restarts the fright; otherwise frames advance only outside IDLE
  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    flash_cnt_d   = flash_cnt_q;
    flash_phase_d = flash_phase_q;
    if (fright_start) begin
      state_d       = ST_FRIGHT;
      frame_cnt_d   = '0;
      flash_cnt_d   = '0;
      flash_phase_d = 1'b0;
    end else if (start_of_frame && state_q == ST_FRIGHT) begin
      frame_cnt_d   = frame_cnt_q + 1'b1;
      state_d       = frame_cnt_q == FLASH_AT ? ST_FLASH : ST_FRIGHT;
      flash_cnt_d   = '0;
      flash_phase_d = 1'b0;
    end else if (start_of_frame && state_q == ST_FLASH) begin
      state_d       = frame_cnt_q == LAST_FRAME ? ST_IDLE : ST_FLASH;
      frame_cnt_d   = frame_cnt_q == LAST_FRAME ? '0 : frame_cnt_q + 1'b1;
      flash_cnt_d   = frame_cnt_q == LAST_FRAME || flash_cnt_q == FLASH_LAST ? '0 : flash_cnt_q + 1'b1;
      flash_phase_d = frame_cnt_q == LAST_FRAME ? 1'b0 : flash_phase_q ^ (flash_cnt_q == FLASH_LAST);
    end
    fright_active_d = state_d != ST_IDLE;
  end
  // State and counter registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      frame_cnt_q     <= '0;
      flash_cnt_q     <= '0;
      flash_phase_q   <= 1'b0;
      fright_active_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      frame_cnt_q     <= frame_cnt_d;
      flash_cnt_q     <= flash_cnt_d;
      flash_phase_q   <= flash_phase_d;
      fright_active_q <= fright_active_d;
    end
  end
  assign state         = state_q;
  assign flash_phase   = flash_phase_q;
  assign fright_active = fright_active_q;
endmodule

// File: rtl/draw_layer_arbiter.sv
// draw_layer_arbiter: fixed-priority sprite layer mux with frightened-ghost recolouring
module draw_layer_arbiter
  import draw_layer_arbiter_pkg::*;
#(
  parameter int         FRIGHT_FRAMES = 360,
  parameter int         FLASH_FRAMES  = 120,
  parameter int         FLASH_PERIOD  = 15,
  parameter logic [7:0] FRIGHT_RGB    = DEFAULT_FRIGHT_RGB,
  parameter logic [7:0] FLASH_RGB     = DEFAULT_FLASH_RGB
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       frightStart,
  input  logic       pacmanDrawReq,
  input  logic [7:0] pacmanRGB,
  input  logic       ghostsDrawReq,
  input  logic [7:0] ghostsRGB,
  input  logic       bordersDrawReq,
  input  logic [7:0] bordersRGB,
  input  logic       dotsDrawReq,
  input  logic [7:0] dotsRGB,
  input  logic [7:0] bgRGB,
  output logic [7:0] RGBOut,
  output logic [2:0] layerSel,
  output logic       frightActive,
  output logic       flashPhase
);
  fright_state_e state;
  logic [7:0]    ghost_rgb, rgb_d, rgb_q;
  layer_e        layer_d, layer_q;
  fright_timer #(
    .FRIGHT_FRAMES(FRIGHT_FRAMES),
    .FLASH_FRAMES (FLASH_FRAMES),
    .FLASH_PERIOD (FLASH_PERIOD)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .start_of_frame(startOfFrame),
    .fright_start  (frightStart),
    .state         (state),
    .flash_phase   (flashPhase),
    .fright_active (frightActive)
  );
  // Ghost colour comes from registered fright state so frightStart never reaches the pixel path
  always_comb begin
    ghost_rgb = state == ST_FRIGHT ? FRIGHT_RGB :
                state == ST_FLASH  ? (flashPhase ? FLASH_RGB : FRIGHT_RGB) : ghostsRGB;
    layer_d   = pacmanDrawReq  ? LAYER_PACMAN  :
                ghostsDrawReq  ? LAYER_GHOSTS  :
                bordersDrawReq ? LAYER_BORDERS :
                dotsDrawReq    ? LAYER_DOTS    : LAYER_BG;
    rgb_d     = pacmanDrawReq  ? pacmanRGB  :
                ghostsDrawReq  ? ghost_rgb  :
                bordersDrawReq ? bordersRGB :
                dotsDrawReq    ? dotsRGB    : bgRGB;
  end
  // One-cycle pixel output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q   <= 8'h00;
      layer_q <= LAYER_BG;
    end else begin
      rgb_q   <= rgb_d;
      layer_q <= layer_d;
    end
  end
  assign RGBOut   = rgb_q;
  assign layerSel = layer_q;
endmodule

// File: tb/tb_draw_layer_arbiter.sv
// tb_draw_layer_arbiter: scoreboard bench for layer priority and fright timing
module tb_draw_layer_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startOfFrame = 1'b0, frightStart = 1'b0;
  logic       pacmanDrawReq = 1'b0, ghostsDrawReq = 1'b0, bordersDrawReq = 1'b0, dotsDrawReq = 1'b0;
  logic [7:0] pacmanRGB = 8'hE0, ghostsRGB = 8'hA5, bordersRGB = 8'h92, dotsRGB = 8'h1C, bgRGB = 8'h01;
  logic [7:0] RGBOut;
  logic [2:0] layerSel;
  logic       frightActive, flashPhase;
  int         tests = 0, fails = 0, nstep = 0;
  localparam logic [3:0] GH = 4'b0100;
  typedef struct {
    logic [7:0] rgb;
    logic [2:0] lay;
    logic       fa;
    logic       fp;
    int         id;
  } exp_t;
  exp_t sb[$];

  draw_layer_arbiter #(
    .FRIGHT_FRAMES(6),
    .FLASH_FRAMES (2),
    .FLASH_PERIOD (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .startOfFrame  (startOfFrame),
    .frightStart   (frightStart),
    .pacmanDrawReq (pacmanDrawReq),
    .pacmanRGB     (pacmanRGB),
    .ghostsDrawReq (ghostsDrawReq),
    .ghostsRGB     (ghostsRGB),
    .bordersDrawReq(bordersDrawReq),
    .bordersRGB    (bordersRGB),
    .dotsDrawReq   (dotsDrawReq),
    .dotsRGB       (dotsRGB),
    .bgRGB         (bgRGB),
    .RGBOut        (RGBOut),
    .layerSel      (layerSel),
    .frightActive  (frightActive),
    .flashPhase    (flashPhase)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [12:0] act, input logic [12:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got rgb=%h lay=%0d fa=%b fp=%b, expected rgb=%h lay=%0d fa=%b fp=%b",
               nm, act[12:5], act[4:2], act[1], act[0], exp[12:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  task automatic step(input logic sof, input logic fs, input logic [3:0] req,
                      input logic [7:0] ergb, input logic [2:0] elay, input logic efa, input logic efp);
    exp_t e;
    startOfFrame = sof;
    frightStart  = fs;
    {pacmanDrawReq, ghostsDrawReq, bordersDrawReq, dotsDrawReq} = req;
    e = '{ergb, elay, efa, efp, nstep};
    sb.push_back(e);
    nstep++;
    @(negedge clk);
  endtask

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("step%0d", e.id), {RGBOut, layerSel, frightActive, flashPhase},
            {e.rgb, e.lay, e.fa, e.fp});
    end
  end

  initial begin
    #1;
    check("reset", {RGBOut, layerSel, frightActive, flashPhase}, 13'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    step(0, 0, 4'b1111, 8'hE0, 3'd4, 0, 0);
    step(0, 0, 4'b0001, 8'h1C, 3'd1, 0, 0);
    step(0, 0, 4'b0000, 8'h01, 3'd0, 0, 0);
    step(0, 0, 4'b0011, 8'h92, 3'd2, 0, 0);
    step(0, 0, GH,      8'hA5, 3'd3, 0, 0);
    step(0, 0, 4'b0110, 8'hA5, 3'd3, 0, 0);
    step(1, 0, GH,      8'hA5, 3'd3, 0, 0);
    // full fright run
    step(0, 1, GH,      8'hA5, 3'd3, 1, 0);
    step(0, 0, GH,      8'h03, 3'd3, 1, 0);
    step(0, 0, 4'b1100, 8'hE0, 3'd4, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, GH, 8'h03, 3'd3, 1, 0);
    step(1, 0, GH,      8'h03, 3'd3, 1, 0);
    step(0, 0, GH,      8'h03, 3'd3, 1, 0);
    step(1, 0, GH,      8'h03, 3'd3, 1, 1);
    step(0, 0, GH,      8'hFF, 3'd3, 1, 1);
    step(0, 0, 4'b0010, 8'h92, 3'd2, 1, 1);
    step(1, 0, GH,      8'hFF, 3'd3, 0, 0);
    step(0, 0, GH,      8'hA5, 3'd3, 0, 0);
    // restart during flash
    step(0, 1, GH,      8'hA5, 3'd3, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, GH, 8'h03, 3'd3, 1, 0);
    step(1, 0, GH,      8'h03, 3'd3, 1, 1);
    step(0, 0, GH,      8'hFF, 3'd3, 1, 1);
    step(0, 1, GH,      8'hFF, 3'd3, 1, 0);
    step(0, 0, GH,      8'h03, 3'd3, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, GH, 8'h03, 3'd3, 1, 0);
    step(1, 0, GH,      8'h03, 3'd3, 1, 1);
    step(1, 0, GH,      8'hFF, 3'd3, 0, 0);
    step(0, 0, GH,      8'hA5, 3'd3, 0, 0);
    // frightStart coinciding with startOfFrame mid-fright
    step(0, 1, GH,      8'hA5, 3'd3, 1, 0);
    step(1, 0, GH,      8'h03, 3'd3, 1, 0);
    step(1, 0, GH,      8'h03, 3'd3, 1, 0);
    step(1, 1, GH,      8'h03, 3'd3, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, GH, 8'h03, 3'd3, 1, 0);
    step(1, 0, GH,      8'h03, 3'd3, 1, 1);
    step(1, 0, GH,      8'hFF, 3'd3, 0, 0);
    // asynchronous reset while flashing
    step(0, 1, GH,      8'hA5, 3'd3, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, GH, 8'h03, 3'd3, 1, 0);
    step(1, 0, GH,      8'h03, 3'd3, 1, 1);
    step(0, 0, GH,      8'hFF, 3'd3, 1, 1);
    reset = 1'b1;
    #1;
    check("async_reset", {RGBOut, layerSel, frightActive, flashPhase}, 13'd0);
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, GH,      8'hA5, 3'd3, 0, 0);
    step(0, 0, 4'b0000, 8'h01, 3'd0, 0, 0);
    {startOfFrame, frightStart, pacmanDrawReq, ghostsDrawReq, bordersDrawReq, dotsDrawReq} = '0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/draw_layer_arbiter.md
DRAW_LAYER_ARBITER -- requirements
Module: draw_layer_arbiter

Interface
REQ-001 Parameter FRIGHT_FRAMES, default 360, meaning total frightened duration in frames (>= FLASH_FRAMES+1).
REQ-002 Parameter FLASH_FRAMES, default 120, meaning trailing part of fright in which ghosts flash (>= 1).
REQ-003 Parameter FLASH_PERIOD, default 15, meaning frames per flash half-cycle (>= 1).
REQ-004 Parameters FRIGHT_RGB 8'h03 and FLASH_RGB 8'hFF, meaning ghost colour in fright and flash-alternate phase (RRRGGGBB).
REQ-005 Ports: clk in 1 system clock; reset in 1 asynchronous, active-high.
REQ-006 startOfFrame in 1 one-cycle pulse per frame; frightStart in 1 one-cycle pulse when a power pellet is eaten.
REQ-007 pacmanDrawReq in 1 / pacmanRGB in 8 top layer request and colour.
REQ-008 ghostsDrawReq in 1 / ghostsRGB in 8 second layer.
REQ-009 bordersDrawReq in 1 / bordersRGB in 8 third layer.
REQ-010 dotsDrawReq in 1 / dotsRGB in 8 fourth layer; bgRGB in 8 background colour.
REQ-011 RGBOut out 8 arbitrated pixel colour; layerSel out 3 winning layer code (0 bg, 1 dots, 2 borders, 3 ghosts, 4 pacman).
REQ-012 frightActive out 1 high in FRIGHT or FLASH; flashPhase out 1 current flash half-cycle.

Function
REQ-013 Fixed priority pacman > ghosts > borders > dots > background; highest asserted request wins each cycle.
REQ-014 RGBOut and layerSel registered: pixel inputs at cycle n appear at cycle n+1 (latency 1).
REQ-015 Ghost layer colour: IDLE ghostsRGB; FRIGHT FRIGHT_RGB; FLASH FRIGHT_RGB when flashPhase=0, FLASH_RGB when flashPhase=1; only applied when ghosts win.
REQ-016 FSM states IDLE, FRIGHT, FLASH; frame counter frameCnt width $clog2(FRIGHT_FRAMES), unsigned, counts startOfFrame pulses.
REQ-017 frightStart in any state: next state FRIGHT, frameCnt<=0, flashPhase<=0, flashCnt<=0 (restart, no extension arithmetic).
REQ-018 frightStart and startOfFrame same cycle: frightStart wins, that frame not counted.
REQ-019 FRIGHT on startOfFrame: frameCnt++; when frameCnt == FRIGHT_FRAMES-FLASH_FRAMES-1 go FLASH, flashPhase<=0, flashCnt<=0.
REQ-020 FLASH on startOfFrame: frameCnt++, flashCnt++; when flashCnt == FLASH_PERIOD-1 toggle flashPhase, flashCnt<=0.
REQ-021 FLASH on startOfFrame with frameCnt == FRIGHT_FRAMES-1: go IDLE, frameCnt<=0, flashPhase<=0; takes priority over REQ-020.
REQ-022 IDLE: counters held at 0; startOfFrame ignored.
REQ-023 State changes take effect at the clock edge following the pulse; colour selection uses registered state (no combinational path from frightStart to RGBOut).
REQ-024 frightActive and flashPhase registered, change in the same cycle as the state register.

Reset
REQ-025 reset asserted: state IDLE, frameCnt 0, flashCnt 0, flashPhase 0, frightActive 0, RGBOut 8'h00, layerSel 0, asynchronously.
REQ-026 reset mid-fright aborts fright immediately; first cycle after release arbitrates normally from IDLE.

Structure
REQ-027 Shared package holds layer-code enum, fright state enum and default colour constants (FRIGHT_RGB, FLASH_RGB).
REQ-028 One sub-module fright_timer (FSM + frame/flash counters, outputs state and flashPhase); priority mux and output register in top.

Verification (sim params FRIGHT_FRAMES=6, FLASH_FRAMES=2, FLASH_PERIOD=1)
REQ-029 All requests high, pacmanRGB 8'hE0 -> next cycle RGBOut 8'hE0, layerSel 4; only dots (8'h1C) -> RGBOut 8'h1C, layerSel 1.
REQ-030 frightStart then 4 startOfFrame pulses -> FLASH after 4th; ghosts-only pixel gives 8'h03 before, alternates 8'hFF/8'h03 per frame after.
REQ-031 Continue: 6th counted startOfFrame -> IDLE, frightActive 0, ghost pixel shows ghostsRGB.
REQ-032 frightStart during FLASH (frame 5) -> FRIGHT, frameCnt 0, flashPhase 0, full 6 frames again.
REQ-033 frightStart and startOfFrame same cycle -> frameCnt 0, FLASH reached only after 4 further pulses.
REQ-034 reset asserted in FLASH with RGBOut 8'hFF -> RGBOut 8'h00, frightActive 0 without clock edge; after release ghosts show ghostsRGB.
